// File: rtl/alt_mem_ddrx_id_pool_arbiter.sv
// Free-ID pool sequencer: seeds the showahead free-ID FIFO after reset, then grants IDs
// round-robin among requesters and pushes returned IDs back, tracking the outstanding count.
module alt_mem_ddrx_id_pool_arbiter #(
    parameter int ID_WIDTH = 3,
    parameter int NUM_REQ  = 4
) (
    input  logic                ctl_clk,
    input  logic                ctl_reset,
    input  logic                fifo_get_valid,
    output logic                fifo_get_ready,
    input  logic [ID_WIDTH-1:0] fifo_get_data,
    output logic                fifo_put_valid,
    input  logic                fifo_put_ready,
    output logic [ID_WIDTH-1:0] fifo_put_data,
    input  logic [NUM_REQ-1:0]  alloc_req,
    output logic [NUM_REQ-1:0]  alloc_grant,
    output logic [ID_WIDTH-1:0] alloc_id,
    input  logic                free_valid,
    output logic                free_ready,
    input  logic [ID_WIDTH-1:0] free_id,
    output logic                init_done,
    output logic [ID_WIDTH:0]   outstanding,
    output logic                err_double_free
);

    localparam int NUM_IDS = 2 ** ID_WIDTH;
    localparam int RR_W    = $clog2(NUM_REQ);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [RR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH:0]   outstanding_q, outstanding_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  eligible;
    logic [RR_W-1:0]     cand;
    logic [RR_W-1:0]     winner;
    logic                found;
    logic                free_acc;

    // Requester index rr_ptr+off, wrapped for non-power-of-two NUM_REQ.
    function automatic logic [RR_W-1:0] wrap_idx(input logic [RR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[RR_W-1:0];
    endfunction

    always_comb begin
        eligible = alloc_req & {NUM_REQ{fifo_get_valid}};
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_idx(rr_ptr_q, i);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // NOTE: every output and _d signal gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        rr_ptr_d       = rr_ptr_q;
        outstanding_d  = outstanding_q;
        err_d          = err_q;
        alloc_grant    = '0;
        alloc_id       = fifo_get_data;
        fifo_get_ready = 1'b0;
        fifo_put_valid = 1'b0;
        fifo_put_data  = free_id;
        free_ready     = 1'b0;
        free_acc       = 1'b0;
        init_done      = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                fifo_put_valid = 1'b1;
                fifo_put_data  = init_cnt_q;
                if (fifo_put_ready) begin
                    if (init_cnt_q == ID_WIDTH'(NUM_IDS - 1)) state_d = ST_RUN;
                    else                                       init_cnt_d = init_cnt_q + ID_WIDTH'(1);
                end
            end
            ST_RUN: begin
                init_done = 1'b1;
                if (found) begin
                    alloc_grant    = NUM_REQ'(1) << winner;
                    fifo_get_ready = 1'b1;
                    rr_ptr_d       = (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + RR_W'(1);
                end
                free_ready = fifo_put_ready;
                free_acc   = free_valid & fifo_put_ready;
                // A free with nothing outstanding is swallowed so the pool never holds duplicates.
                if (free_acc) begin
                    if (outstanding_q != '0) fifo_put_valid = 1'b1;
                    else                     err_d          = 1'b1;
                end
                unique case ({found, fifo_put_valid})
                    2'b10:   outstanding_d = outstanding_q + (ID_WIDTH+1)'(1);
                    2'b01:   outstanding_d = outstanding_q - (ID_WIDTH+1)'(1);
                    default: outstanding_d = outstanding_q;
                endcase
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign outstanding     = outstanding_q;
    assign err_double_free = err_q;

endmodule

// File: tb/tb_alt_mem_ddrx_id_pool_arbiter.sv
// Bench for the ID pool arbiter: bench-side showahead FIFO, a pool-level reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_alt_mem_ddrx_id_pool_arbiter;

    localparam int ID_WIDTH   = 3;
    localparam int NUM_REQ    = 4;
    localparam int NUM_IDS    = 8;
    localparam int FIFO_DEPTH = 16;

    logic                ctl_clk = 1'b0;
    logic                ctl_reset;
    logic                fifo_get_valid;
    logic                fifo_get_ready;
    logic [ID_WIDTH-1:0] fifo_get_data;
    logic                fifo_put_valid;
    logic                fifo_put_ready;
    logic [ID_WIDTH-1:0] fifo_put_data;
    logic [NUM_REQ-1:0]  alloc_req;
    logic [NUM_REQ-1:0]  alloc_grant;
    logic [ID_WIDTH-1:0] alloc_id;
    logic                free_valid;
    logic                free_ready;
    logic [ID_WIDTH-1:0] free_id;
    logic                init_done;
    logic [ID_WIDTH:0]   outstanding;
    logic                err_double_free;

    alt_mem_ddrx_id_pool_arbiter #(.ID_WIDTH(ID_WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .ctl_clk(ctl_clk), .ctl_reset(ctl_reset),
        .fifo_get_valid(fifo_get_valid), .fifo_get_ready(fifo_get_ready), .fifo_get_data(fifo_get_data),
        .fifo_put_valid(fifo_put_valid), .fifo_put_ready(fifo_put_ready), .fifo_put_data(fifo_put_data),
        .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_id(alloc_id),
        .free_valid(free_valid), .free_ready(free_ready), .free_id(free_id),
        .init_done(init_done), .outstanding(outstanding), .err_double_free(err_double_free)
    );

    always #5 ctl_clk = ~ctl_clk;

    // Bench-side free FIFO
    int   fifo_q[$];
    int   fifo_cnt = 0;
    logic put_en;
    assign fifo_put_ready = put_en && (fifo_cnt < FIFO_DEPTH);

    bit pend_reset, pend_pop, pend_push;
    int pend_data;

    // Reference model: pool contents, seeding position, last winner, outstanding, sticky error
    bit m_run, m_err;
    int m_seed, m_last, m_out;
    int m_pool[$];

    int   push_log[$];
    logic [NUM_REQ-1:0]  obs_grant;
    logic [ID_WIDTH-1:0] obs_id;
    logic [ID_WIDTH-1:0] obs_put_data;
    logic [ID_WIDTH:0]   obs_out;
    logic obs_get_ready, obs_put_valid, obs_free_ready, obs_init_done, obs_err;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int  win;
        int  r;
        bit  acc, push;
        obs_grant      = alloc_grant;
        obs_id         = alloc_id;
        obs_put_data   = fifo_put_data;
        obs_out        = outstanding;
        obs_get_ready  = fifo_get_ready;
        obs_put_valid  = fifo_put_valid;
        obs_free_ready = free_ready;
        obs_init_done  = init_done;
        obs_err        = err_double_free;
        pend_pop  = 1'b0;
        pend_push = 1'b0;
        pend_data = 0;
        if (ctl_reset) begin
            pend_reset = 1'b1;
            m_run = 1'b0; m_err = 1'b0; m_seed = 0; m_last = NUM_REQ - 1; m_out = 0;
            m_pool.delete();
            return;
        end
        pend_reset = 1'b0;
        check("outstanding", outstanding, m_out);
        check("err_double_free", err_double_free, m_err);
        check("init_done", init_done, m_run);
        if (!m_run) begin
            check("init_grant", alloc_grant, 0);
            check("init_get_ready", fifo_get_ready, 0);
            check("init_free_ready", free_ready, 0);
            check("init_put_valid", fifo_put_valid, 1);
            check("init_put_data", fifo_put_data, m_seed);
            if (fifo_put_ready) begin
                m_pool.push_back(m_seed);
                if (m_seed == NUM_IDS - 1) m_run = 1'b1;
                else                       m_seed++;
            end
        end else begin
            win = -1;
            if (fifo_get_valid) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    r = (m_last + k) % NUM_REQ;
                    if (win < 0 && alloc_req[r]) win = r;
                end
            end
            check("grant", alloc_grant, (win < 0) ? 0 : (1 << win));
            check("get_ready", fifo_get_ready, win >= 0);
            if (win >= 0) begin
                if (m_pool.size() == 0) check("pool_nonempty", 0, 1);
                else                    check("alloc_id", alloc_id, m_pool[0]);
            end
            check("free_ready", free_ready, fifo_put_ready);
            acc  = free_valid && fifo_put_ready;
            push = acc && (m_out > 0);
            check("put_valid", fifo_put_valid, push);
            if (push) check("put_data", fifo_put_data, free_id);
            if (acc && m_out == 0) m_err = 1'b1;
            if (win >= 0) begin
                if (m_pool.size() > 0) void'(m_pool.pop_front());
                m_last = win;
                m_out++;
            end
            if (push) begin
                m_pool.push_back(free_id);
                m_out--;
            end
        end
        pend_pop  = fifo_get_ready && fifo_get_valid;
        pend_push = fifo_put_valid && fifo_put_ready;
        pend_data = fifo_put_data;
        if (pend_push) push_log.push_back(int'(fifo_put_data));
    endtask

    task automatic apply_fifo();
        if (pend_reset) fifo_q.delete();
        else begin
            if (pend_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (pend_push) fifo_q.push_back(pend_data);
        end
        fifo_cnt       = fifo_q.size();
        fifo_get_valid = (fifo_cnt > 0);
        fifo_get_data  = (fifo_cnt > 0) ? fifo_q[0][ID_WIDTH-1:0] : '0;
    endtask

    // One clock: compare at the falling edge, advance the bench FIFO just after the rising edge.
    task automatic step();
        @(negedge ctl_clk);
        model_check();
        @(posedge ctl_clk);
        #1;
        apply_fifo();
    endtask

    task automatic check_seed_log(input string name);
        check({name, "_count"}, push_log.size(), NUM_IDS);
        for (int i = 0; i < NUM_IDS; i++)
            if (i < push_log.size()) check(name, push_log[i], i);
    endtask

    int exp_win[6] = '{0, 1, 2, 3, 0, 1};
    int exp_ids5[5] = '{7, 0, 1, 2, 5};

    initial begin
        ctl_reset = 1'b1; put_en = 1'b1; alloc_req = '0;
        free_valid = 1'b0; free_id = '0;
        fifo_get_valid = 1'b0; fifo_get_data = '0;
        step(); step();

        // Seeding with a 3-cycle stall on fifo_put_ready; requests must be ignored
        ctl_reset = 1'b0; alloc_req = 4'b1111;
        push_log.delete();
        step();
        check("rst_grant", obs_grant, 0);
        check("rst_get_ready", obs_get_ready, 0);
        check("rst_free_ready", obs_free_ready, 0);
        check("rst_init_done", obs_init_done, 0);
        check("rst_first_push", obs_put_data, 0);
        step(); step();
        put_en = 1'b0;
        repeat (3) step();
        check("stall_holds_data", obs_put_data, 3);
        put_en = 1'b1; alloc_req = '0;
        repeat (5) step();
        check("last_init_cycle", obs_init_done, 0);
        check_seed_log("seed");
        step();
        check("run_init_done", obs_init_done, 1);

        // All four requesting: round-robin 0,1,2,3,0,1 with IDs 0..5
        alloc_req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_grant", obs_grant, 1 << exp_win[i]);
            check("rr_id", obs_id, i);
        end
        alloc_req = '0;
        step();
        check("out_after_6", obs_out, 6);

        // Free 0,1,2, then allocate to req2 while freeing 5 in the same cycle
        free_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            free_id = 3'(i);
            step();
        end
        alloc_req = 4'b0100; free_id = 3'd5;
        step();
        check("same_cycle_out", obs_out, 3);
        check("same_cycle_grant", obs_grant, 4'b0100);
        check("same_cycle_id", obs_id, 6);
        check("same_cycle_push", obs_put_valid, 1);
        check("same_cycle_push_id", obs_put_data, 5);
        free_valid = 1'b0; alloc_req = '0;
        step();
        check("out_after_swap", obs_out, 3);

        // Drain the pool through req0, stall while empty, then reuse a freed ID
        alloc_req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            check("drain_grant", obs_grant, 1);
            check("drain_id", obs_id, exp_ids5[i]);
        end
        step(); step();
        check("empty_no_grant", obs_grant, 0);
        check("empty_no_pop", obs_get_ready, 0);
        check("out_full", obs_out, 8);
        free_valid = 1'b1; free_id = 3'd2;
        step();
        check("free_cycle_no_grant", obs_grant, 0);
        check("free_cycle_push", obs_put_valid, 1);
        free_valid = 1'b0;
        step();
        check("reuse_grant", obs_grant, 1);
        check("reuse_id", obs_id, 2);
        alloc_req = '0;
        step();
        check("out_still_8", obs_out, 8);

        // Back-pressure, return everything, then a double free and a mid-run reset
        put_en = 1'b0; free_valid = 1'b1; free_id = 3'd0;
        step();
        check("bp_free_ready", obs_free_ready, 0);
        check("bp_no_push", obs_put_valid, 0);
        put_en = 1'b1;
        for (int i = 0; i < NUM_IDS; i++) begin
            free_id = 3'(i);
            step();
        end
        free_id = 3'd3;
        step();
        check("dbl_free_ready", obs_free_ready, 1);
        check("dbl_no_push", obs_put_valid, 0);
        check("dbl_err_not_yet", obs_err, 0);
        free_valid = 1'b0;
        step();
        check("dbl_err_set", obs_err, 1);
        check("dbl_out_zero", obs_out, 0);
        step();
        check("dbl_err_sticky", obs_err, 1);

        ctl_reset = 1'b1;
        step();
        ctl_reset = 1'b0;
        push_log.delete();
        step();
        check("reset_err_clear", obs_err, 0);
        check("reset_init_done", obs_init_done, 0);
        check("reset_out", obs_out, 0);
        repeat (NUM_IDS - 1) step();
        check_seed_log("reseed");
        step();
        check("reseed_done", obs_init_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
